// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backed by a word-addressed register array.
// It stands in for the MIG AXI port so cores can run without DDR. The write
// and read channels are independent FSMs that support FIXED and INCR bursts.
// The memory array is never reset, so its contents survive rst.
module axi_mem_responder #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int DEPTH_LOG2     = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                s_axi_awid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic [3:0]                s_axi_awqos,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [3:0]                s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [3:0]                s_axi_arid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [3:0]                s_axi_rid,
    output logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int IDX_LSB = 4;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [7:0] CNT_ONE = 8'd1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} WState;
    typedef enum logic {R_IDLE, R_DATA} RState;

    logic [APP_DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_live;
    WState                 r_wState, w_wNext;
    RState                 r_rState, w_rNext;

    logic [3:0]            r_wId;
    logic [DEPTH_LOG2-1:0] r_wIdx;
    logic [7:0]            r_wLen, r_wCnt;
    logic                  r_wBad, r_wFixed, r_wErr;

    logic [3:0]            r_rId;
    logic [DEPTH_LOG2-1:0] r_rIdx;
    logic [7:0]            r_rLen, r_rCnt;
    logic                  r_rBad, r_rFixed;
    logic [APP_DATA_WIDTH-1:0] r_rData;

    logic                  w_awHs, w_wHs, w_wLastBeat;
    logic                  w_arHs, w_rHs, w_rLastBeat;
    logic [DEPTH_LOG2-1:0] w_rFetchIdx;
    logic                  w_unused;

    assign w_awHs      = s_axi_awvalid && s_axi_awready;
    assign w_wHs       = s_axi_wvalid && s_axi_wready;
    assign w_wLastBeat = (r_wCnt == r_wLen);
    assign w_arHs      = s_axi_arvalid && s_axi_arready;
    assign w_rHs       = s_axi_rvalid && s_axi_rready;
    assign w_rLastBeat = (r_rCnt == r_rLen);

    // Word fetched for the R channel: the AR address on accept, else the next burst word.
    assign w_rFetchIdx = w_arHs   ? s_axi_araddr[IDX_LSB +: DEPTH_LOG2] :
                         r_rFixed ? r_rIdx : r_rIdx + IDX_ONE;

    assign w_unused = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                        s_axi_awaddr[IDX_LSB-1:0], s_axi_awaddr[APP_ADDR_WIDTH-1:IDX_LSB+DEPTH_LOG2],
                        s_axi_araddr[IDX_LSB-1:0], s_axi_araddr[APP_ADDR_WIDTH-1:IDX_LSB+DEPTH_LOG2]};

    // Holds the address-ready outputs low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_live <= 1'b0;
        else     r_live <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wState <= W_IDLE;
        else     r_wState <= w_wNext;
    end

    // Write FSM next state: the beat counter, not wlast, decides when data ends.
    always_comb begin
        w_wNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_awHs) w_wNext = W_DATA;
            W_DATA:  if (w_wHs && w_wLastBeat) w_wNext = W_RESP;
            W_RESP:  if (s_axi_bready) w_wNext = W_IDLE;
            default: w_wNext = W_IDLE;
        endcase
    end

    // Write channel outputs decoded from the state.
    always_comb begin
        s_axi_awready = r_live && (r_wState == W_IDLE);
        s_axi_wready  = (r_wState == W_DATA);
        s_axi_bvalid  = (r_wState == W_RESP);
        s_axi_bresp   = (s_axi_bvalid && r_wErr) ? 2'b10 : 2'b00;
        s_axi_bid     = r_wId;
    end

    // Write transaction context: latched on AW accept, advanced per W beat, error flags sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wId    <= '0;
            r_wIdx   <= '0;
            r_wLen   <= '0;
            r_wCnt   <= '0;
            r_wBad   <= 1'b0;
            r_wFixed <= 1'b0;
            r_wErr   <= 1'b0;
        end else if (w_awHs) begin
            r_wId    <= s_axi_awid;
            r_wIdx   <= s_axi_awaddr[IDX_LSB +: DEPTH_LOG2];
            r_wLen   <= s_axi_awlen;
            r_wCnt   <= '0;
            r_wBad   <= s_axi_awburst[1];
            r_wFixed <= (s_axi_awburst == 2'b00);
            r_wErr   <= s_axi_awburst[1];
        end else if (w_wHs) begin
            r_wCnt <= r_wCnt + CNT_ONE;
            if (!r_wFixed) r_wIdx <= r_wIdx + IDX_ONE;
            if (s_axi_wlast != w_wLastBeat) r_wErr <= 1'b1;
        end
    end

    // Byte-enabled memory write; unsupported bursts consume beats without touching memory.
    always_ff @(posedge clk) begin
        if (w_wHs && !r_wBad) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_wIdx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rState <= R_IDLE;
        else     r_rState <= w_rNext;
    end

    // Read FSM next state: leave after the handshake of the final beat.
    always_comb begin
        w_rNext = r_rState;
        case (r_rState)
            R_IDLE:  if (w_arHs) w_rNext = R_DATA;
            R_DATA:  if (w_rHs && w_rLastBeat) w_rNext = R_IDLE;
            default: w_rNext = R_IDLE;
        endcase
    end

    // Read channel outputs; data comes from the registered fetch so it holds while stalled.
    always_comb begin
        s_axi_arready = r_live && (r_rState == R_IDLE);
        s_axi_rvalid  = (r_rState == R_DATA);
        s_axi_rlast   = s_axi_rvalid && w_rLastBeat;
        s_axi_rresp   = (s_axi_rvalid && r_rBad) ? 2'b10 : 2'b00;
        s_axi_rid     = r_rId;
        s_axi_rdata   = r_rData;
    end

    // Read context and data fetch; a same-edge write is not yet visible to this fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rId    <= '0;
            r_rIdx   <= '0;
            r_rLen   <= '0;
            r_rCnt   <= '0;
            r_rBad   <= 1'b0;
            r_rFixed <= 1'b0;
            r_rData  <= '0;
        end else if (w_arHs) begin
            r_rId    <= s_axi_arid;
            r_rIdx   <= w_rFetchIdx;
            r_rLen   <= s_axi_arlen;
            r_rCnt   <= '0;
            r_rBad   <= s_axi_arburst[1];
            r_rFixed <= (s_axi_arburst == 2'b00);
            r_rData  <= s_axi_arburst[1] ? '0 : r_mem[w_rFetchIdx];
        end else if (w_rHs && !w_rLastBeat) begin
            r_rCnt  <= r_rCnt + CNT_ONE;
            r_rIdx  <= w_rFetchIdx;
            r_rData <= r_rBad ? '0 : r_mem[w_rFetchIdx];
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: scoreboard bench for the AXI memory responder.
// Stimulus tasks compute expected B/R responses from a word-level memory
// model and queue them; a monitor pops and compares on every handshake.
module tb_axi_mem_responder;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int DL = 10;
    localparam int NWORDS = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    s_axi_awid;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_awlock;
    logic [3:0]    s_axi_awcache;
    logic [2:0]    s_axi_awprot;
    logic [3:0]    s_axi_awqos;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [MW-1:0] s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [3:0]    s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [3:0]    s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arlock;
    logic [3:0]    s_axi_arcache;
    logic [2:0]    s_axi_arprot;
    logic [3:0]    s_axi_arqos;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [3:0]    s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } BExp;

    typedef struct {
        logic [3:0]    id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } RExp;

    BExp bq[$];
    RExp rq[$];
    logic [DW-1:0] model [int];

    logic [DW-1:0] beatData [64];
    logic [MW-1:0] beatStrb [64];
    logic          beatLast [64];

    int nChecks = 0;
    int nFails  = 0;
    int rMode   = 0;
    bit gapsOn  = 1'b0;

    BExp monB;
    RExp monR;

    axi_mem_responder #(
        .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .DEPTH_LOG2(DL)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: every check counts, every mismatch reports.
    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // R-channel back-pressure: 0 always ready, 1 toggle, 2 random, 3 stalled.
    initial begin
        s_axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rMode)
                0: s_axi_rready = 1'b1;
                1: s_axi_rready = ~s_axi_rready;
                2: s_axi_rready = 1'($urandom_range(0, 1));
                default: s_axi_rready = 1'b0;
            endcase
        end
    end

    // Monitor: pop expectations on handshakes, verify held data during R stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    nChecks++; nFails++;
                    $display("[TB] FAIL unexpected_b: got bid %h, expected no response", s_axi_bid);
                end else begin
                    monB = bq.pop_front();
                    checkOutput("bid", DW'(s_axi_bid), DW'(monB.id));
                    checkOutput("bresp", DW'(s_axi_bresp), DW'(monB.resp));
                end
            end
            if (s_axi_rvalid) begin
                if (rq.size() == 0) begin
                    if (s_axi_rready) begin
                        nChecks++; nFails++;
                        $display("[TB] FAIL unexpected_r: got rdata %h, expected no beat", s_axi_rdata);
                    end
                end else if (s_axi_rready) begin
                    monR = rq.pop_front();
                    checkOutput("rid", DW'(s_axi_rid), DW'(monR.id));
                    checkOutput("rdata", s_axi_rdata, monR.data);
                    checkOutput("rresp", DW'(s_axi_rresp), DW'(monR.resp));
                    checkOutput("rlast", DW'(s_axi_rlast), DW'(monR.last));
                end else begin
                    checkOutput("rdata_stalled", s_axi_rdata, rq[0].data);
                    checkOutput("rlast_stalled", DW'(s_axi_rlast), DW'(rq[0].last));
                end
            end
        end
    end

    task automatic setBeat(input int k, input logic [DW-1:0] d, input logic [MW-1:0] s, input logic l);
        beatData[k] = d;
        beatStrb[k] = s;
        beatLast[k] = l;
    endtask

    // AW handshake with a bounded wait; ok reports whether it happened.
    task automatic awIssue(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output bit ok);
        int t;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awsize = 3'd4; s_axi_awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axi_awready && t < 50) begin @(negedge clk); t++; end
        checkOutput("aw_handshake", DW'(s_axi_awready), DW'(1'b1));
        ok = s_axi_awready;
        if (ok) begin @(posedge clk); #1; end
        s_axi_awvalid = 1'b0;
        if (ok) checkOutput("wready_after_aw", DW'(s_axi_wready), DW'(1'b1));
    endtask

    // AR handshake; expected beats are queued from the model beforehand.
    task automatic arIssue(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output bit ok);
        int t;
        int idx;
        RExp e;
        idx = int'(addr[4 +: DL]);
        for (int k = 0; k <= int'(len); k++) begin
            e.id = id;
            e.last = (k == int'(len));
            e.resp = burst[1] ? 2'b10 : 2'b00;
            e.data = burst[1] ? '0 : model[idx];
            rq.push_back(e);
            if (burst == 2'b01) idx = (idx + 1) % NWORDS;
        end
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arsize = 3'd4; s_axi_arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_axi_arready && t < 50) begin @(negedge clk); t++; end
        checkOutput("ar_handshake", DW'(s_axi_arready), DW'(1'b1));
        ok = s_axi_arready;
        if (ok) begin @(posedge clk); #1; end
        s_axi_arvalid = 1'b0;
        if (ok) checkOutput("rvalid_after_ar", DW'(s_axi_rvalid), DW'(1'b1));
        else rq.delete();
    endtask

    // Full write transaction using the beat tables; model updated per burst rules.
    task automatic writeBurst(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [1:0] burst);
        int t;
        int idx;
        bit err;
        bit ok;
        BExp be;
        logic [DW-1:0] w;
        idx = int'(addr[4 +: DL]);
        err = burst[1];
        for (int k = 0; k <= int'(len); k++) begin
            if (beatLast[k] != (k == int'(len))) err = 1'b1;
            if (!burst[1]) begin
                w = model.exists(idx) ? model[idx] : '0;
                for (int b = 0; b < MW; b++)
                    if (beatStrb[k][b]) w[b*8 +: 8] = beatData[k][b*8 +: 8];
                model[idx] = w;
            end
            if (burst == 2'b01) idx = (idx + 1) % NWORDS;
        end
        be.id = id;
        be.resp = err ? 2'b10 : 2'b00;
        bq.push_back(be);
        awIssue(id, addr, len, burst, ok);
        if (!ok) begin bq.delete(); return; end
        for (int k = 0; k <= int'(len); k++) begin
            if (gapsOn && $urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axi_wvalid = 1'b1; s_axi_wdata = beatData[k];
            s_axi_wstrb = beatStrb[k]; s_axi_wlast = beatLast[k];
            t = 0;
            @(negedge clk);
            while (!s_axi_wready && t < 50) begin @(negedge clk); t++; end
            if (!s_axi_wready) begin
                checkOutput("w_handshake", DW'(s_axi_wready), DW'(1'b1));
                s_axi_wvalid = 1'b0;
                bq.delete();
                return;
            end
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        checkOutput("bvalid_after_last_w", DW'(s_axi_bvalid), DW'(1'b1));
        t = 0;
        while (bq.size() != 0 && t < 50) begin @(posedge clk); t++; end
        checkOutput("b_drained", DW'(bq.size() == 0), DW'(1'b1));
        bq.delete();
        #1;
        checkOutput("awready_after_b", DW'(s_axi_awready), DW'(1'b1));
    endtask

    // Full read transaction, draining all queued beats through the monitor.
    task automatic readBurst(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        int t;
        bit ok;
        arIssue(id, addr, len, burst, ok);
        if (!ok) return;
        t = 0;
        while (rq.size() != 0 && t < 300) begin @(posedge clk); t++; end
        checkOutput("r_drained", DW'(rq.size() == 0), DW'(1'b1));
        rq.delete();
        #1;
        checkOutput("arready_after_r", DW'(s_axi_arready), DW'(1'b1));
    endtask

    // Directed plan followed by randomized bursts.
    task automatic applyStimulus();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [7:0]    len;
        logic [1:0]    burst;
        int            word;
        int            t;
        bit            ok;
        BExp           be;
        RExp           re;

        $display("[TB] single beat write/read");
        setBeat(0, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 1'b1);
        writeBurst(4'd3, 28'h20, 8'd0, 2'b01);
        readBurst(4'd3, 28'h20, 8'd0, 2'b01);

        $display("[TB] partial strobe");
        setBeat(0, {DW{1'b1}}, 16'hFFFF, 1'b1);
        writeBurst(4'd5, 28'h20, 8'd0, 2'b01);
        setBeat(0, '0, 16'h000F, 1'b1);
        writeBurst(4'd6, 28'h20, 8'd0, 2'b01);
        readBurst(4'd7, 28'h20, 8'd0, 2'b01);

        $display("[TB] INCR burst with toggling rready");
        for (int k = 0; k < 4; k++) setBeat(k, DW'(k + 1), 16'hFFFF, k == 3);
        writeBurst(4'd1, 28'h100, 8'd3, 2'b01);
        rMode = 1;
        readBurst(4'd2, 28'h100, 8'd3, 2'b01);
        rMode = 0;

        $display("[TB] FIXED burst");
        setBeat(0, {4{32'hAAAA_0001}}, 16'hFFFF, 1'b0);
        setBeat(1, {4{32'hBBBB_0002}}, 16'hFFFF, 1'b0);
        setBeat(2, {4{32'hCCCC_0003}}, 16'hFFFF, 1'b1);
        writeBurst(4'd4, 28'h40, 8'd2, 2'b00);
        readBurst(4'd4, 28'h40, 8'd0, 2'b01);

        $display("[TB] error responses");
        setBeat(0, {4{$urandom}}, 16'hFFFF, 1'b0);
        setBeat(1, {4{$urandom}}, 16'hFFFF, 1'b1);
        writeBurst(4'd9, 28'h20, 8'd1, 2'b10);
        readBurst(4'd9, 28'h20, 8'd0, 2'b01);
        setBeat(0, {4{$urandom}}, 16'hFFFF, 1'b1);
        setBeat(1, {4{$urandom}}, 16'hFFFF, 1'b0);
        writeBurst(4'd10, 28'h60, 8'd1, 2'b01);
        readBurst(4'd10, 28'h60, 8'd1, 2'b01);
        readBurst(4'd11, 28'h20, 8'd1, 2'b11);

        $display("[TB] INCR wrap at top of memory and address aliasing");
        for (int k = 0; k < 4; k++) setBeat(k, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, k == 3);
        writeBurst(4'd12, 28'h3FE0, 8'd3, 2'b01);
        readBurst(4'd12, 28'h0103FE0, 8'd3, 2'b01);

        $display("[TB] same-edge write and read of one word");
        setBeat(0, {4{32'h0DD0_1111}}, 16'hFFFF, 1'b1);
        writeBurst(4'd2, 28'h3000, 8'd0, 2'b01);
        d = {$urandom, $urandom, $urandom, $urandom};
        re.id = 4'd8; re.data = model[int'(10'h300)]; re.resp = 2'b00; re.last = 1'b1;
        rq.push_back(re);
        be.id = 4'd13; be.resp = 2'b00;
        bq.push_back(be);
        model[int'(10'h300)] = d;
        awIssue(4'd13, 28'h3000, 8'd0, 2'b01, ok);
        s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1;
        s_axi_arid = 4'd8; s_axi_araddr = 28'h3000; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        checkOutput("same_edge_wready", DW'(s_axi_wready), DW'(1'b1));
        checkOutput("same_edge_arready", DW'(s_axi_arready), DW'(1'b1));
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 50) begin @(posedge clk); t++; end
        checkOutput("same_edge_drained", DW'(rq.size() == 0 && bq.size() == 0), DW'(1'b1));
        rq.delete(); bq.delete();
        @(posedge clk); #1;
        readBurst(4'd8, 28'h3000, 8'd0, 2'b01);

        $display("[TB] reset during a 4-beat read");
        for (int k = 0; k < 4; k++) setBeat(k, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, k == 3);
        writeBurst(4'd14, 28'h200, 8'd3, 2'b01);
        @(negedge clk); rMode = 3;
        @(posedge clk); #1;
        arIssue(4'd15, 28'h200, 8'd3, 2'b01, ok);
        repeat (2) @(posedge clk);
        @(negedge clk); rMode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); rMode = 3;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rvalid_in_reset", DW'(s_axi_rvalid), DW'(1'b0));
        checkOutput("arready_in_reset", DW'(s_axi_arready), DW'(1'b0));
        checkOutput("rdata_in_reset", s_axi_rdata, '0);
        rq.delete();
        rMode = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arready_before_edge", DW'(s_axi_arready), DW'(1'b0));
        @(posedge clk); #1;
        checkOutput("arready_after_release", DW'(s_axi_arready), DW'(1'b1));
        readBurst(4'd15, 28'h200, 8'd3, 2'b01);

        $display("[TB] randomized bursts");
        for (int k = 0; k < 64; k++) setBeat(k, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, k == 63);
        writeBurst(4'd0, 28'h400, 8'd63, 2'b01);
        gapsOn = 1'b1;
        rMode = 2;
        for (int i = 0; i < 20; i++) begin
            word  = 64 + int'($urandom_range(0, 55));
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 1));
            for (int k = 0; k <= int'(len); k++)
                setBeat(k, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), k == int'(len));
            a = AW'($urandom);
            a[4 +: DL] = 10'(word);
            writeBurst(4'($urandom), a, len, burst);
            a = AW'($urandom);
            a[4 +: DL] = 10'(word);
            readBurst(4'($urandom), a, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 1)));
        end
        rMode = 0;
        gapsOn = 1'b0;
    endtask

    // Reset checks, then the stimulus plan, then the summary.
    initial begin
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        #12;
        checkOutput("reset_awready", DW'(s_axi_awready), DW'(1'b0));
        checkOutput("reset_wready", DW'(s_axi_wready), DW'(1'b0));
        checkOutput("reset_bvalid", DW'(s_axi_bvalid), DW'(1'b0));
        checkOutput("reset_bresp_bid", DW'({s_axi_bresp, s_axi_bid}), DW'(6'd0));
        checkOutput("reset_arready", DW'(s_axi_arready), DW'(1'b0));
        checkOutput("reset_rvalid_rlast", DW'({s_axi_rvalid, s_axi_rlast}), DW'(2'd0));
        checkOutput("reset_rresp_rid", DW'({s_axi_rresp, s_axi_rid}), DW'(6'd0));
        checkOutput("reset_rdata", s_axi_rdata, '0);
        #10;
        rst = 1'b0;
        #1;
        checkOutput("awready_before_first_edge", DW'(s_axi_awready), DW'(1'b0));
        @(posedge clk); #1;
        checkOutput("awready_first_edge", DW'(s_axi_awready), DW'(1'b1));
        checkOutput("arready_first_edge", DW'(s_axi_arready), DW'(1'b1));
        applyStimulus();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
